// File: rtl/hwpe_stream_tcdm_fetch.sv
// hwpe_stream_tcdm_fetch: generator-driven TCDM read fetch with a credit-controlled
// response FIFO, presented as an HWPE stream with busy/done reporting.
module hwpe_stream_tcdm_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [CNT-1:0]          trans_size_i,
  input  logic [31:0]             gen_addr_i,
  input  logic [DATA_WIDTH/8-1:0] gen_strb_i,
  output logic                    gen_enable_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [31:0]             tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  input  logic                    tcdm_r_valid_i,
  output logic                    stream_valid_o,
  input  logic                    stream_ready_i,
  output logic [DATA_WIDTH-1:0]   stream_data_o,
  output logic [DATA_WIDTH/8-1:0] stream_strb_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [CNT-1:0] size, issued;
  logic outstanding;
  logic [SW-1:0] pend_strb;
  logic [DATA_WIDTH+SW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] fifo_cnt;
  logic kill, fire, push, pop, last, done_q, done_nxt, unused;
  assign unused = test_mode_i;
  assign kill = ~rst_ni | clear_i;
  assign fire = gen_enable_o;
  // only a response to our own grant is accepted; strays and post-clear beats drop here
  assign push = tcdm_r_valid_i & outstanding;
  assign pop = stream_valid_o & stream_ready_i;
  assign last = issued + CNT'(1) == size;
  always_ff @(posedge clk_i) begin
    state <= kill ? IDLE : state_nxt;
  end
  always_comb begin
    state_nxt = state;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = start_i & |trans_size_i ? RUN : IDLE;
        done_nxt = start_i & ~|trans_size_i;
      end
      RUN: state_nxt = fire & last ? DRAIN : RUN;
      DRAIN: begin
        // leave as the final beat pops so done and busy-low land together
        done_nxt = ~outstanding & (~|fifo_cnt | (fifo_cnt == (AW+1)'(1) & pop));
        state_nxt = done_nxt ? IDLE : DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    tcdm_req_o = (state == RUN) & (issued < size) & (fifo_cnt + (AW+1)'(outstanding) < (AW+1)'(FIFO_DEPTH));
    gen_enable_o = tcdm_req_o & tcdm_gnt_i;
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (kill) begin
      size <= '0;
      issued <= '0;
      outstanding <= 1'b0;
      pend_strb <= '0;
      wptr <= '0;
      rptr <= '0;
      fifo_cnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if (state == IDLE & start_i) begin
        size <= trans_size_i;
        issued <= '0;
      end
      if (fire) begin
        issued <= issued + CNT'(1);
        pend_strb <= gen_strb_i;
      end
      outstanding <= fire | (outstanding & ~push);
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= {tcdm_r_data_i, pend_strb};
  end
  assign stream_valid_o = |fifo_cnt;
  assign {stream_data_o, stream_strb_o} = stream_valid_o ? mem[rptr] : '0;
  assign tcdm_add_o = tcdm_req_o ? gen_addr_i : '0;
  assign tcdm_be_o = tcdm_req_o ? gen_strb_i : '0;
  assign tcdm_wen_o = 1'b1;
  assign done_o = done_q;
endmodule
